// File: rtl/intdiv_otf_conv.sv
// On-the-fly SD2 quotient converter: folds one signed digit per cycle into Q and QM = Q-1.
// Optional final non-restoring correction selected by define INTDIV_OTF_CORR_EN.
module intdiv_otf_conv #(
    parameter int unsigned N  = 16,
    parameter int unsigned CW = 7
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         digit_valid,
    input  logic [1:0]   digit,
`ifdef INTDIV_OTF_CORR_EN
    input  logic         rem_neg,
`endif
    output logic         busy,
    output logic         done,
    output logic [N:0]   q_out
);

    typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

    state_e        state;
    logic [N:0]    q;
    logic [N:0]    qm;
    logic [N:0]    q_nxt;
    logic [N:0]    qm_nxt;
    logic [N:0]    q_final;
    logic [CW-1:0] cnt;
    logic          last;

    assign last = (cnt == CW'(N - 1));

    // Digit encoding is (p,n) = p - n; both 00 and 11 mean zero.
    always_comb begin
        q_nxt  = {q[N-1:0], 1'b0};
        qm_nxt = {qm[N-1:0], 1'b1};
        case (digit)
            2'b10: begin
                q_nxt  = {q[N-1:0], 1'b1};
                qm_nxt = {q[N-1:0], 1'b0};
            end
            2'b01: begin
                q_nxt  = {qm[N-1:0], 1'b1};
                qm_nxt = {qm[N-1:0], 1'b0};
            end
            default: begin
                q_nxt  = {q[N-1:0], 1'b0};
                qm_nxt = {qm[N-1:0], 1'b1};
            end
        endcase
    end

`ifdef INTDIV_OTF_CORR_EN
    // A negative final remainder means the quotient is one ulp too large.
    assign q_final = rem_neg ? qm_nxt : q_nxt;
`else
    assign q_final = q_nxt;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= StIdle;
            q     <= '0;
            qm    <= '1;
            cnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            q_out <= '0;
        end else if (start) begin
            // Restart wins over any coincident digit; q_out keeps the last result.
            state <= StConv;
            q     <= '0;
            qm    <= '1;
            cnt   <= '0;
            busy  <= 1'b1;
            done  <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    busy <= 1'b0;
                    done <= 1'b0;
                end
                StConv: begin
                    if (digit_valid) begin
                        q   <= q_nxt;
                        qm  <= qm_nxt;
                        cnt <= cnt + CW'(1);
                        if (last) begin
                            state <= StDone;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            q_out <= q_final;
                        end
                    end
                end
                StDone: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intdiv_otf_conv.sv
// Directed bench for intdiv_otf_conv (N=4) plus random digit streams on an N=16 instance.
// Runs the correction checks only when INTDIV_OTF_CORR_EN is defined.
module tb_intdiv_otf_conv;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start, digit_valid;
    logic [1:0] digit;
    logic       busy, done;
    logic [4:0] q_out;

    logic        start16, dv16;
    logic [1:0]  dig16;
    logic        busy16, done16;
    logic [16:0] q_out16;

`ifdef INTDIV_OTF_CORR_EN
    logic rem_neg;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    intdiv_otf_conv #(.N(4), .CW(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .digit_valid (digit_valid),
        .digit       (digit),
`ifdef INTDIV_OTF_CORR_EN
        .rem_neg     (rem_neg),
`endif
        .busy        (busy),
        .done        (done),
        .q_out       (q_out)
    );

    intdiv_otf_conv #(.N(16), .CW(5)) dut16 (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start16),
        .digit_valid (dv16),
        .digit       (dig16),
`ifdef INTDIV_OTF_CORR_EN
        .rem_neg     (1'b0),
`endif
        .busy        (busy16),
        .done        (done16),
        .q_out       (q_out16)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: apply inputs, let one rising edge pass, return at the next negedge.
    task automatic cyc(input logic s, input logic v, input logic [1:0] d);
        start = s; digit_valid = v; digit = d;
        @(negedge clk);
    endtask

    task automatic cyc16(input logic s, input logic v, input logic [1:0] d);
        start16 = s; dv16 = v; dig16 = d;
        @(negedge clk);
    endtask

    initial begin
        longint      acc;
        logic [1:0]  dg;
        logic [63:0] expv;

        rst_n = 1'b0; start = 0; digit_valid = 0; digit = 0;
        start16 = 0; dv16 = 0; dig16 = 0;
`ifdef INTDIV_OTF_CORR_EN
        rem_neg = 0;
`endif
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_qout", q_out, 5'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // +1,0,-1,+1 -> +7
        cyc(1, 0, 2'b00); chk("t1_busy_start", busy, 1);
        cyc(0, 1, 2'b10); chk("t1_busy_d1", busy, 1);
        cyc(0, 1, 2'b00); chk("t1_busy_d2", busy, 1);
        cyc(0, 1, 2'b01); chk("t1_busy_d3", busy, 1);
        chk("t1_done_early", done, 0);
        cyc(0, 1, 2'b10);
        chk("t1_done", done, 1);
        chk("t1_busy_done", busy, 0);
        chk("t1_qout", q_out, 5'b00111);
        cyc(0, 0, 2'b00);
        chk("t1_done_pulse", done, 0);

        // -1 x4 -> -15
        cyc(1, 0, 2'b00);
        repeat (4) cyc(0, 1, 2'b01);
        chk("t2_qout_neg15", q_out, 5'b10001);
        cyc(0, 0, 2'b00);

        // +1 x4 -> +15
        cyc(1, 0, 2'b00);
        repeat (4) cyc(0, 1, 2'b10);
        chk("t3_qout_pos15", q_out, 5'b01111);
        cyc(0, 0, 2'b00);

        // 11,00,stall x3,10,00 -> +2
        cyc(1, 0, 2'b00);
        cyc(0, 1, 2'b11);
        cyc(0, 1, 2'b00);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 2'b10);
            chk("t4_stall_busy", busy, 1);
            chk("t4_stall_done", done, 0);
            chk("t4_stall_qout", q_out, 5'b01111);
        end
        cyc(0, 1, 2'b10);
        chk("t4_not_done", done, 0);
        cyc(0, 1, 2'b00);
        chk("t4_done", done, 1);
        chk("t4_qout", q_out, 5'b00010);
        cyc(0, 0, 2'b00);
        chk("t4_done_once", done, 0);
        cyc(0, 0, 2'b00);
        chk("t4_done_once2", done, 0);

        // Abort after 2 digits; coincident digit dropped; then +1,+1,0,0 -> +12
        cyc(1, 0, 2'b00);
        cyc(0, 1, 2'b10);
        cyc(0, 1, 2'b10);
        cyc(1, 1, 2'b10);
        chk("t5_qout_kept", q_out, 5'b00010);
        chk("t5_busy", busy, 1);
        cyc(0, 1, 2'b10);
        cyc(0, 1, 2'b10);
        cyc(0, 1, 2'b00);
        chk("t5_not_done", done, 0);
        cyc(0, 1, 2'b00);
        chk("t5_done", done, 1);
        chk("t5_qout", q_out, 5'b01100);
        cyc(0, 0, 2'b00);
        for (int i = 0; i < 5; i++) cyc(0, 1, 2'b01);
        chk("t5_idle_qout", q_out, 5'b01100);
        chk("t5_idle_busy", busy, 0);
        chk("t5_idle_done", done, 0);

        // Asynchronous reset after digit 3
        cyc(1, 0, 2'b00);
        repeat (3) cyc(0, 1, 2'b10);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_busy", busy, 0);
        chk("t6_rst_done", done, 0);
        chk("t6_rst_qout", q_out, 5'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(0, 1, 2'b10);
        chk("t6_idle_after_rst", busy, 0);
        cyc(1, 0, 2'b00);
        cyc(0, 1, 2'b00);
        cyc(0, 1, 2'b00);
        cyc(0, 1, 2'b00);
        cyc(0, 1, 2'b10);
        chk("t6_done", done, 1);
        chk("t6_qout", q_out, 5'd1);
        cyc(0, 0, 2'b00);

`ifdef INTDIV_OTF_CORR_EN
        cyc(1, 0, 2'b00);
        cyc(0, 1, 2'b10); cyc(0, 1, 2'b00); cyc(0, 1, 2'b01);
        rem_neg = 1'b1;
        cyc(0, 1, 2'b10);
        rem_neg = 1'b0;
        chk("t7_corr_neg", q_out, 5'd6);
        cyc(0, 0, 2'b00);
        cyc(1, 0, 2'b00);
        rem_neg = 1'b1;
        cyc(0, 1, 2'b10); cyc(0, 1, 2'b00); cyc(0, 1, 2'b01);
        rem_neg = 1'b0;
        cyc(0, 1, 2'b10);
        chk("t7_corr_pos", q_out, 5'd7);
        cyc(0, 0, 2'b00);
`endif

        // N=16 random streams against the weighted digit sum
        for (int r = 0; r < 6; r++) begin
            acc = 0;
            cyc16(1, 0, 2'b00);
            for (int i = 0; i < 16; i++) begin
                dg = 2'($urandom_range(0, 3));
                if (r == 0) dg = 2'b01;
                if (r == 1) dg = 2'b10;
                if (dg == 2'b10) acc = acc + (64'sd1 <<< (15 - i));
                else if (dg == 2'b01) acc = acc - (64'sd1 <<< (15 - i));
                if (i == 7) cyc16(0, 0, 2'b10);
                cyc16(0, 1, dg);
            end
            expv = 64'(acc) & 64'h1FFFF;
            chk("t8_rand_done", done16, 1);
            chk("t8_rand_qout", q_out16, expv);
            cyc16(0, 0, 2'b00);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
